// File: rtl/led_scan_if.sv
// Bus between the LED scan driver and its host:
// display value and controls in, scan outputs toward the decoder.
interface led_scan_if #(
    parameter int NDIG = 4
);
    logic [4*NDIG-1:0] value;
    logic              load;
    logic              lz_en;
    logic [3:0]        number;
    logic [NDIG-1:0]   digit_sel;
    logic              frame_done;

    modport master (
        output value, load, lz_en,
        input  number, digit_sel, frame_done
    );

    modport slave (
        input  value, load, lz_en,
        output number, digit_sel, frame_done
    );
endinterface

// File: rtl/led_scan_driver.sv
// Time-multiplexed 7-segment scan controller with frame-aligned
// value update, per-slot blanking and leading-zero suppression.
module led_scan_driver #(
    parameter int NDIG      = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    led_scan_if.slave   bus
);
    localparam int TW = $clog2(SCAN_DIV);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int VW = 4 * NDIG;

    logic [TW-1:0]   timer, timer_n;
    logic [IW-1:0]   idx, idx_n;
    logic [VW-1:0]   active, active_n, shadow;
    logic            pending;
    logic            wrap, bnd;
    logic [NDIG-1:0] hide;
    logic            zacc;
    logic            sup;
    logic [3:0]      num_n;
    logic [NDIG-1:0] sel_n;
    logic            fd_n;

    always_comb begin
        wrap     = timer == TW'(SCAN_DIV - 1);
        bnd      = wrap && (idx == IW'(NDIG - 1));
        timer_n  = wrap ? '0 : timer + 1'b1;
        idx_n    = idx;
        if (bnd)
            idx_n = '0;
        else if (wrap)
            idx_n = idx + 1'b1;
        active_n = active;
        if (bnd) begin
            if (bus.load)
                active_n = bus.value;
            else if (pending)
                active_n = shadow;
        end
    end

    // hide[i]: nibbles i..NDIG-1 of the next displayed value are all zero
    always_comb begin
        zacc = 1'b1;
        hide = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zacc    = zacc & (active_n[4*i +: 4] == 4'd0);
            hide[i] = zacc;
        end
    end

    // Outputs are registered, so they are computed from next-state values
    always_comb begin
        num_n = active_n[{idx_n, 2'b00} +: 4];
        sup   = bus.lz_en && (idx_n != '0) && hide[idx_n];
        if ((timer_n < TW'(BLANK_CYC)) || sup)
            sel_n = '0;
        else
            sel_n = NDIG'(1) << idx_n;
        fd_n  = (timer_n == '0) && (idx_n == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer          <= '0;
            idx            <= '0;
            active         <= '0;
            shadow         <= '0;
            pending        <= 1'b0;
            bus.number     <= '0;
            bus.digit_sel  <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            timer  <= timer_n;
            idx    <= idx_n;
            active <= active_n;
            if (bnd) begin
                pending <= 1'b0;
            end else if (bus.load) begin
                shadow  <= bus.value;
                pending <= 1'b1;
            end
            bus.number     <= num_n;
            bus.digit_sel  <= sel_n;
            bus.frame_done <= fd_n;
        end
    end
endmodule
